// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and constants for the TDC frame scheduler
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PUSH = 2'b01,
        ST_WAIT = 2'b11
    } tdc_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // sync + seq + length ahead of the payload, checksum behind it
    localparam int HDR_TRL_BYTES = 4;

endpackage

// File: rtl/tdc_frame_sched_if.sv
// rtl/tdc_frame_sched_if.sv - byte push/done handshake toward the UART transmitter
interface tdc_frame_sched_if;

    logic       tx_push;
    logic [7:0] tx_byte;
    logic       tx_done;

    modport master (
        output tx_push,
        output tx_byte,
        input  tx_done
    );

    modport slave (
        input  tx_push,
        input  tx_byte,
        output tx_done
    );

endinterface

// File: rtl/tdc_byte_sel.sv
// rtl/tdc_byte_sel.sv - combinational selector of the frame byte at a given pointer
module tdc_byte_sel
    import tdc_pkg::*;
#(
    parameter int         DATASIZE  = 128,
    parameter int         PW        = 5,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic [DATASIZE-1:0] snap_r,
    input  logic [PW-1:0]       ptr,
    input  logic [7:0]          seq,
    input  logic [7:0]          nb,
    input  logic [7:0]          chk,
    output logic [7:0]          frame_byte
);

    localparam int NB = DATASIZE / 8;

    logic [7:0] payload [NB];

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_payload
            assign payload[k] = snap_r[8*k +: 8];
        end
    endgenerate

    // anything past the payload is the checksum slot
    always_comb begin
        frame_byte = chk;
        if (ptr == PW'(0)) begin
            frame_byte = SYNC_BYTE;
        end else if (ptr == PW'(1)) begin
            frame_byte = seq;
        end else if (ptr == PW'(2)) begin
            frame_byte = nb;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (ptr == PW'(i + 3)) begin
                    frame_byte = payload[i];
                end
            end
        end
    end

endmodule

// File: rtl/tdc_frame_sched.sv
// rtl/tdc_frame_sched.sv - snapshots the TDC word per tick and sends it as a framed UART packet
module tdc_frame_sched
    import tdc_pkg::*;
#(
    parameter int         DATASIZE  = 128,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                clk10m,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic [DATASIZE-1:0] snap_data,
    tdc_frame_sched_if.master   tx,
    output logic                busy,
    output logic [7:0]          seq_num,
    output logic [7:0]          overrun_cnt
);

    localparam int             NB        = DATASIZE / 8;
    localparam int             FRAME_LEN = NB + HDR_TRL_BYTES;
    localparam int             PW        = $clog2(FRAME_LEN);
    localparam logic [PW-1:0]  LAST_PTR  = PW'(FRAME_LEN - 1);
    localparam logic [7:0]     NB_BYTE   = 8'(NB);

    tdc_state_t          state_q;
    tdc_state_t          state_d;
    logic [DATASIZE-1:0] snap_r;
    logic [PW-1:0]       ptr_q;
    logic [7:0]          chk_r;
    logic [7:0]          sel_byte;
    logic                tx_push_q;
    logic [7:0]          tx_byte_q;

    logic accept;
    logic do_push;
    logic step;
    logic finish;
    logic drop;

    assign tx.tx_push = tx_push_q;
    assign tx.tx_byte = tx_byte_q;

    tdc_byte_sel #(
        .DATASIZE  (DATASIZE),
        .PW        (PW),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_byte_sel (
        .snap_r     (snap_r),
        .ptr        (ptr_q),
        .seq        (seq_num),
        .nb         (NB_BYTE),
        .chk        (chk_r),
        .frame_byte (sel_byte)
    );

    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_tick) state_d = ST_PUSH;
            ST_PUSH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx.tx_done) begin
                    state_d = (ptr_q == LAST_PTR) ? ST_IDLE : ST_PUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        do_push = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: accept = sample_tick;
            ST_PUSH: do_push = 1'b1;
            ST_WAIT: begin
                if (tx.tx_done) begin
                    finish = (ptr_q == LAST_PTR);
                    step   = (ptr_q != LAST_PTR);
                end
            end
            default: ;
        endcase
        // a tick coinciding with the final done still finds the FSM in WAIT
        drop = sample_tick && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            tx_push_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
            busy        <= 1'b0;
            seq_num     <= 8'h00;
            overrun_cnt <= 8'h00;
            ptr_q       <= '0;
            chk_r       <= 8'h00;
            snap_r      <= '0;
        end else begin
            tx_push_q <= do_push;
            if (accept) begin
                snap_r <= snap_data;
                ptr_q  <= '0;
                chk_r  <= 8'h00;
                busy   <= 1'b1;
            end
            if (do_push) begin
                tx_byte_q <= sel_byte;
                if (ptr_q != PW'(0) && ptr_q != LAST_PTR) begin
                    chk_r <= chk_r ^ sel_byte;
                end
            end
            if (step) begin
                ptr_q <= ptr_q + PW'(1);
            end
            if (finish) begin
                busy    <= 1'b0;
                seq_num <= seq_num + 8'd1;
            end
            if (drop && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_frame_sched.sv
// tb/tb_tdc_frame_sched.sv - directed self-checking bench for tdc_frame_sched
module tb_tdc_frame_sched;

    logic         clk10m = 1'b0;
    logic         rst_n;
    logic         sample_tick;
    logic [127:0] snap_data;
    logic         busy;
    logic [7:0]   seq_num;
    logic [7:0]   overrun_cnt;

    logic         model_done = 1'b0;
    logic         spur_man = 1'b0;
    logic         spur_auto = 1'b0;
    logic         spur_en = 1'b0;
    logic         prev_push = 1'b0;
    int           uart_delay = 10;
    int           cnt = 0;
    int           dbl_push = 0;
    int           bad_busy = 0;
    int           vectors = 0;
    int           miscompares = 0;
    logic [7:0]   push_q [$];
    logic [7:0]   exp_f [20];
    logic [127:0] snap_ramp;

    tdc_frame_sched_if bus ();

    assign bus.tx_done = model_done | spur_man | spur_auto;

    tdc_frame_sched #(
        .DATASIZE  (128),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk10m      (clk10m),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .snap_data   (snap_data),
        .tx          (bus.master),
        .busy        (busy),
        .seq_num     (seq_num),
        .overrun_cnt (overrun_cnt)
    );

    always #50 clk10m = ~clk10m;

    // UART stand-in: records every push and answers it with a done pulse uart_delay cycles later
    always @(negedge clk10m) begin
        spur_auto  = spur_en && model_done;
        model_done = 1'b0;
        if (bus.tx_push) begin
            push_q.push_back(bus.tx_byte);
            if (prev_push) dbl_push++;
            if (!busy) bad_busy++;
        end
        prev_push = bus.tx_push;
        if (!rst_n) begin
            cnt = 0;
        end else if (bus.tx_push) begin
            cnt = uart_delay;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) model_done = 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk10m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (push_q.size() >= 20 && !busy) break;
            cyc();
        end
        chk({tag, "_push_count"}, push_q.size(), 20);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] seq, input logic [127:0] snap);
        logic [7:0] c;
        exp_f[0] = 8'hA5;
        exp_f[1] = seq;
        exp_f[2] = 8'h10;
        c = seq ^ 8'h10;
        for (int k = 0; k < 16; k++) begin
            exp_f[3 + k] = snap[8*k +: 8];
            c = c ^ snap[8*k +: 8];
        end
        exp_f[19] = c;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < push_q.size()) ? push_q[i] : 8'hxx, exp_f[i]);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) snap_ramp[8*k +: 8] = 8'(k);
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        snap_data   = snap_ramp;
        cyc();
        cyc();
        chk("rst_tx_push", bus.tx_push, 0);
        chk("rst_tx_byte", bus.tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_overrun", overrun_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // first frame: ramp payload, seq 0, start latency
        push_q.delete();
        tick();
        chk("s1_busy_after_tick", busy, 1);
        chk("s1_no_push_yet", bus.tx_push, 0);
        cyc();
        chk("s1_first_push", bus.tx_push, 1);
        chk("s1_first_byte", bus.tx_byte, 8'hA5);
        chk("s1_seq_mid", seq_num, 0);
        wait_frame("s1");
        check_frame("s1", 8'h00, snap_ramp);
        chk("s1_chk_const", push_q[19], 8'h10);
        chk("s1_seq_after", seq_num, 1);
        chk("s1_busy_after", busy, 0);

        // second frame carries seq 1
        push_q.delete();
        tick();
        wait_frame("s2");
        check_frame("s2", 8'h01, snap_ramp);
        chk("s2_chk_const", push_q[19], 8'h11);
        chk("s2_seq_after", seq_num, 2);

        // dropped ticks: one 3 cycles in, one on the final done
        push_q.delete();
        tick();
        cyc();
        cyc();
        snap_data = {16{8'hFF}};
        tick();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (push_q.size() == 20 && model_done) begin
                sample_tick = 1'b1;
                cyc();
                sample_tick = 1'b0;
                break;
            end
        end
        wait_frame("s3");
        check_frame("s3", 8'h02, snap_ramp);
        chk("s3_overrun", overrun_cnt, 2);
        for (int i = 0; i < 40; i++) cyc();
        chk("s3_single_frame", push_q.size(), 20);
        chk("s3_busy_idle", busy, 0);
        chk("s3_seq_after", seq_num, 3);
        snap_data = snap_ramp;

        // reset after the 7th push aborts the frame
        push_q.delete();
        tick();
        for (int i = 0; i < 1000; i++) begin
            if (push_q.size() >= 7) break;
            cyc();
        end
        chk("s5_seven_pushes", push_q.size(), 7);
        rst_n = 1'b0;
        #1;
        chk("s5_push_cleared", bus.tx_push, 0);
        chk("s5_busy_cleared", busy, 0);
        chk("s5_seq_cleared", seq_num, 0);
        chk("s5_overrun_cleared", overrun_cnt, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) cyc();
        chk("s5_no_more_pushes", push_q.size(), 7);
        push_q.delete();
        tick();
        wait_frame("s5");
        check_frame("s5", 8'h00, snap_ramp);

        // spurious dones in IDLE and PUSH must not move the pointer
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        push_q.delete();
        spur_man = 1'b1;
        cyc();
        cyc();
        spur_man = 1'b0;
        cyc();
        spur_en = 1'b1;
        tick();
        spur_man = 1'b1;
        cyc();
        spur_man = 1'b0;
        wait_frame("s6");
        check_frame("s6", 8'h00, snap_ramp);
        chk("s6_seq_after", seq_num, 1);
        spur_en = 1'b0;
        cyc();

        // 300 ticks during one slow frame saturate the overrun count
        uart_delay = 40;
        push_q.delete();
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            cyc();
        end
        chk("s4_overrun_sat", overrun_cnt, 8'hFF);
        chk("s4_still_busy", busy, 1);
        wait_frame("s4");
        check_frame("s4", 8'h01, snap_ramp);
        chk("s4_overrun_held", overrun_cnt, 8'hFF);

        chk("no_back_to_back_push", dbl_push, 0);
        chk("busy_at_every_push", bad_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
